// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and defaults for the serial pattern-scan controller and its detector core.
package seq_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int           DEF_WORD_W  = 16;
  localparam int           DEF_PAT_W   = 6;
  localparam logic [5:0]   DEF_PATTERN = 6'b111010;

  // first_pos reads all-ones when a word produced no match
  localparam bit           POS_NONE_BIT = 1'b1;

endpackage

// File: rtl/seq_scan_ctrl_det_core.sv
// Overlapping Mealy detector: hit is combinational on the incoming bit and the
// registered history of the last PAT_W-1 bits.
module seq_det_core
  import seq_scan_ctrl_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic hit
);

  localparam int                HIST_W   = PAT_W - 1;
  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [HIST_W-1:0] hist;
  logic [FILL_W-1:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_en) begin
      hist <= HIST_W'({hist, bit_in});
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

  always_comb begin
    hit = (fill >= FILL_MAX) && ({hist, bit_in} == PATTERN);
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts parallel words, serializes them MSB-first through seq_det_core and
// reports per-word match count and first match position over valid/ready.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int               WORD_W  = DEF_WORD_W,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_cont,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_pos,
  output logic              match_any
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] POS_NONE = {CNT_W{POS_NONE_BIT}};

  state_t             state, state_n;
  logic [WORD_W-1:0]  shreg;
  logic [CNT_W-1:0]   idx;
  logic               accept;
  logic               det_clr;
  logic               det_en;
  logic               hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          det_clr = !in_cont;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy   = 1'b1;
        det_en = 1'b1;
        if (idx == LAST_IDX) state_n = ST_REPORT;
      end
      ST_REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      idx       <= '0;
      match_cnt <= '0;
      first_pos <= POS_NONE;
    end else if (accept) begin
      shreg     <= in_word;
      idx       <= '0;
      match_cnt <= '0;
      first_pos <= POS_NONE;
    end else if (det_en) begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
      idx   <= idx + 1'b1;
      if (hit) begin
        match_cnt <= match_cnt + 1'b1;
        // a zero count means this hit is the first of the word
        if (match_cnt == '0) first_pos <= idx;
      end
    end
  end

  always_comb begin
    match_any = (match_cnt != '0);
  end

  seq_det_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (det_clr),
    .bit_en (det_en),
    .bit_in (shreg[WORD_W-1]),
    .hit    (hit)
  );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: a sliding-window bitstream model predicts
// each word's result; a negedge monitor pops and compares on every handshake.
module tb_seq_scan_ctrl;

  localparam int              WORD_W = 16;
  localparam int              PAT_W  = 6;
  localparam int              CNT_W  = 5;
  localparam logic [PAT_W-1:0] PAT   = 6'b111010;
  localparam int              NONE   = 31;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_word = '0;
  logic              in_cont = 1'b0;
  logic              busy;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  first_pos;
  logic              match_any;

  seq_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_cont   (in_cont),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .match_cnt (match_cnt),
    .first_pos (first_pos),
    .match_any (match_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int cnt;
    int pos;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  bit   win_q[$];
  bit   rand_rdy = 1'b0;
  bit   prev_ov  = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the bitstream as a sliding window of the last PAT_W bits.
  function automatic exp_t model(input logic [WORD_W-1:0] w, input bit cont, input int acc);
    exp_t e;
    e.cnt = 0;
    e.pos = NONE;
    e.acc = acc;
    if (!cont) win_q.delete();
    for (int i = 0; i < WORD_W; i++) begin
      win_q.push_back(w[WORD_W-1-i]);
      if (win_q.size() > PAT_W) void'(win_q.pop_front());
      if (win_q.size() == PAT_W) begin
        bit m;
        m = 1'b1;
        for (int j = 0; j < PAT_W; j++)
          if (win_q[j] != PAT[PAT_W-1-j]) m = 1'b0;
        if (m) begin
          if (e.cnt == 0) e.pos = i;
          e.cnt++;
        end
      end
    end
    return e;
  endfunction

  task automatic send(input logic [WORD_W-1:0] w, input bit cont, input bit expect_out);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    in_word  = w;
    in_cont  = cont;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("accept_ready", int'(in_ready), 1);
    e = model(w, cont, cyc + 1);
    if (expect_out) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready),  1);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_match_cnt"}, int'(match_cnt), 0);
    chk({tag, "_first_pos"}, int'(first_pos), NONE);
    chk({tag, "_match_any"}, int'(match_any), 0);
  endtask

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom % 4) != 0;
    end
  end

  // Monitor: latency on the rising out_valid, payload on the handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else                   chk("latency", cyc - exp_q[0].acc, WORD_W);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("match_cnt", int'(match_cnt), e.cnt);
        chk("first_pos", int'(first_pos), e.pos);
        chk("match_any", int'(match_any), int'(e.cnt != 0));
        chk("report_in_ready", int'(in_ready), 0);
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [WORD_W-1:0] w;
    int sh;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed words
    send(16'b1110_1000_0000_0000, 1'b0, 1'b1);
    send(16'b1110_1011_1010_0000, 1'b0, 1'b1);
    send(16'h0007, 1'b0, 1'b1);
    send(16'h4000, 1'b1, 1'b1);
    send(16'h0007, 1'b0, 1'b1);
    send(16'h4000, 1'b0, 1'b1);
    send(16'hFFFF, 1'b0, 1'b1);
    send(16'h0000, 1'b0, 1'b1);
    drain();

    // backpressure in REPORT
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'b1110_1011_1010_0000, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("bp_valid_rise", int'(out_valid), 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = k[0];
      in_word  = WORD_W'($urandom);
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_match_cnt", int'(match_cnt), exp_q[0].cnt);
      chk("bp_first_pos", int'(first_pos), exp_q[0].pos);
      chk("bp_in_ready",  int'(in_ready),  0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready",  int'(in_ready),  1);
    chk("bp_idle_out_valid", int'(out_valid), 0);
    drain();

    // reset in the middle of SHIFT, at idx=8
    send(16'b1110_1011_1010_0000, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    win_q.delete();
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst_no_out_valid", n, 0);
    send(16'b0101_0000_0000_0000, 1'b1, 1'b1);
    drain();

    // randomized words with random consumer stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      w = WORD_W'($urandom);
      if ($urandom % 2) begin
        sh = $urandom_range(0, WORD_W - PAT_W);
        w[sh +: PAT_W] = PAT;
      end
      send(w, ($urandom % 3) != 0, 1'b1);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
